// File: rtl/quad_decoder_pkg.sv
// Shared types and the Gray-code step decoder for the quadrature decoder.
package quad_pkg;

    localparam int QD_ACC_W = 3;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } qd_state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        INC     = 2'd1,
        DEC     = 2'd2,
        ILLEGAL = 2'd3
    } qd_step_t;

    // Clockwise successor in the sequence 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] qd_cw_next(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = 2'b01;
            2'b01:   nxt = 2'b11;
            2'b11:   nxt = 2'b10;
            2'b10:   nxt = 2'b00;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    function automatic qd_step_t qd_decode(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        qd_step_t step;
        if (cur_ab == prev_ab) begin
            step = NONE;
        end else if ((cur_ab ^ prev_ab) == 2'b11) begin
            step = ILLEGAL;
        end else if (cur_ab == qd_cw_next(prev_ab)) begin
            step = INC;
        end else begin
            step = DEC;
        end
        return step;
    endfunction

endpackage

// File: rtl/quad_decoder_debounce_ch.sv
// Single-channel debouncer: accepts a new level only after it has been stable
// for DEB_N consecutive cycles; load bypasses the filter.
module debounce_ch #(
    parameter int DEB_N = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic load,
    output logic dout
);

    localparam int CNT_W = (DEB_N < 2) ? 1 : $clog2(DEB_N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_N - 1);

    if (DEB_N < 1) begin : g_bad_deb_n
        $error("debounce_ch: DEB_N must be >= 1");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dout_q;
    logic             dout_d;

    // Next-state: count disagreement cycles, accept on the DEB_N-th one.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (load) begin
            dout_d = din;
            cnt_d  = {CNT_W{1'b0}};
        end else if (din != dout_q) begin
            if (cnt_q == CNT_LAST) begin
                dout_d = din;
                cnt_d  = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= {CNT_W{1'b0}};
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: synchronize, debounce, decode Gray-code steps and
// divide them down to one en pulse (with cw direction) per DIV edges.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int DEB_N = 1000,
    parameter int DIV   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_in,
    input  logic       b_in,
    output logic       en,
    output logic       cw,
    output logic       err,
    output logic [1:0] ab
);

    localparam int INIT_W = $clog2(DEB_N + 2);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEB_N + 1);
    localparam logic signed [QD_ACC_W-1:0] ACC_MAX = QD_ACC_W'(DIV - 1);
    localparam logic signed [QD_ACC_W-1:0] ACC_MIN = QD_ACC_W'(1 - DIV);

    if (!(DIV == 1 || DIV == 2 || DIV == 4)) begin : g_bad_div
        $error("quad_decoder: DIV must be 1, 2 or 4");
    end

    logic [1:0]                 sync_a_q;
    logic [1:0]                 sync_b_q;
    logic                       s2_a;
    logic                       s2_b;
    logic                       deb_a;
    logic                       deb_b;
    logic                       load_s;
    logic [1:0]                 cur_ab_s;
    qd_step_t                   step_s;

    qd_state_t                  state_q;
    qd_state_t                  state_d;
    logic [INIT_W-1:0]          init_cnt_q;
    logic [INIT_W-1:0]          init_cnt_d;
    logic [1:0]                 prev_ab_q;
    logic [1:0]                 prev_ab_d;
    logic signed [QD_ACC_W-1:0] acc_q;
    logic signed [QD_ACC_W-1:0] acc_d;
    logic                       en_q;
    logic                       en_d;
    logic                       cw_q;
    logic                       cw_d;
    logic                       err_q;
    logic                       err_d;

    assign s2_a     = sync_a_q[1];
    assign s2_b     = sync_b_q[1];
    assign load_s   = (state_q == INIT);
    assign cur_ab_s = {deb_a, deb_b};
    assign step_s   = qd_decode(prev_ab_q, cur_ab_s);

    debounce_ch #(.DEB_N(DEB_N)) u_deb_a (
        .clk  (clk),
        .rst  (rst),
        .din  (s2_a),
        .load (load_s),
        .dout (deb_a)
    );

    debounce_ch #(.DEB_N(DEB_N)) u_deb_b (
        .clk  (clk),
        .rst  (rst),
        .din  (s2_b),
        .load (load_s),
        .dout (deb_b)
    );

    // Two-flop synchronizers for the asynchronous pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a_q <= 2'b00;
            sync_b_q <= 2'b00;
        end else begin
            sync_a_q <= {sync_a_q[0], a_in};
            sync_b_q <= {sync_b_q[0], b_in};
        end
    end

    // FSM, step accumulation and output pulse generation.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_ab_d  = prev_ab_q;
        acc_d      = acc_q;
        en_d       = 1'b0;
        err_d      = 1'b0;
        cw_d       = cw_q;
        case (state_q)
            INIT: begin
                // Track the pins directly so whatever level they settled at is not seen as a step.
                prev_ab_d = {s2_a, s2_b};
                acc_d     = {QD_ACC_W{1'b0}};
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = RUN;
                    init_cnt_d = {INIT_W{1'b0}};
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            RUN: begin
                prev_ab_d = cur_ab_s;
                case (step_s)
                    INC: begin
                        if (acc_q == ACC_MAX) begin
                            en_d  = 1'b1;
                            cw_d  = 1'b1;
                            acc_d = {QD_ACC_W{1'b0}};
                        end else begin
                            acc_d = acc_q + QD_ACC_W'(1);
                        end
                    end
                    DEC: begin
                        if (acc_q == ACC_MIN) begin
                            en_d  = 1'b1;
                            cw_d  = 1'b0;
                            acc_d = {QD_ACC_W{1'b0}};
                        end else begin
                            acc_d = acc_q - QD_ACC_W'(1);
                        end
                    end
                    ILLEGAL: err_d = 1'b1;
                    NONE:    err_d = 1'b0;
                    default: err_d = 1'b0;
                endcase
            end
            default: begin
                state_d    = INIT;
                init_cnt_d = {INIT_W{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= {INIT_W{1'b0}};
            prev_ab_q  <= 2'b00;
            acc_q      <= {QD_ACC_W{1'b0}};
            en_q       <= 1'b0;
            cw_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prev_ab_q  <= prev_ab_d;
            acc_q      <= acc_d;
            en_q       <= en_d;
            cw_q       <= cw_d;
            err_q      <= err_d;
        end
    end

    assign en  = en_q;
    assign cw  = cw_q;
    assign err = err_q;
    assign ab  = cur_ab_s;

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature (A/B) decoder that turns the raw two-phase signals of a rotary encoder into single-cycle `en` step pulses with a `cw` direction flag. These two outputs drive the `en`/`cw` inputs of the team's up/down counter. It sits between the board pins and the counter. It synchronizes and debounces each channel, then decodes Gray-code transitions. An optional divider emits one pulse per detent instead of one per edge.

## Interface
Parameters:
- `DEB_N`, default 1000: number of consecutive cycles a synchronized level must differ from the debounced level before it is accepted; must be ≥1.
- `DIV`, default 4: quadrature edges per output pulse; legal values are 1, 2 and 4, and any other value is an elaboration error.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_in`  in  1  raw encoder channel A; asynchronous to `clk`.
- `b_in`  in  1  raw encoder channel B; asynchronous to `clk`.
- `en`  out  1  one-cycle step pulse.
- `cw`  out  1  direction of the latest pulse: 1 = clockwise (count up). Holds its value between pulses.
- `err`  out  1  one-cycle pulse on an illegal transition (both channels changed at once).
- `ab`  out  2  current debounced `{A,B}`.

## Operation
- Synchronizer: two flops per channel, giving `s2_a` and `s2_b`.
- Debouncer, one per channel:
  - A counter increments while the synchronized level ≠ the debounced level, and clears when they are equal.
  - When the counter would reach `DEB_N`, the debounced level takes the synchronized value and the counter clears.
- FSM, states `INIT` and `RUN`:
  - `INIT` (entered on reset):
    - Each cycle, the debounced and previous-AB registers load directly from `s2` (no debounce).
    - `en` and `err` are held 0.
    - After `DEB_N+2` cycles the FSM moves to `RUN`.
  - `RUN`: each cycle, the current debounced AB is compared with `prev_ab`, then `prev_ab` takes the current value.
- Step decode, with `{A,B}` clockwise order 00→01→11→10→00:
  - Forward neighbour → `INC`.
  - Reverse neighbour → `DEC`.
  - Equal → `NONE`.
  - Both bits differ → `ILLEGAL`.
- Accumulator `acc`: signed, 3 bits, range −(DIV−1)..+(DIV−1).
  - `INC`: if `acc==DIV−1`, pulse `en`, set `cw=1`, set `acc=0`; otherwise `acc+1`.
  - `DEC`: if `acc==−(DIV−1)`, pulse `en`, set `cw=0`, set `acc=0`; otherwise `acc−1`.
  - `ILLEGAL`: pulse `err`; `acc` unchanged; no `en`.
  - With `DIV=1`, every legal step pulses `en`.
- A direction reversal unwinds `acc` naturally; no separate handling.
- `en` and `err` are never high in the same cycle.

## Timing
- Reset values: `en=0`, `cw=0`, `err=0`, `ab=00`, `acc=0`, debounce counters 0, all sync flops 0, FSM in `INIT`.
- `en`, `cw`, `err` and `ab` are all registered outputs.
- Latency: take edge 0 as the first edge that samples a new stable level. The debounced level updates at edge `DEB_N+1`, and `en`/`err` are high for exactly the one cycle following edge `DEB_N+2`.
- Glitch rejection: a pulse shorter than `DEB_N` cycles (after synchronization) produces no `ab` change and no output.
- Simultaneous debounced change on both channels in one cycle → `ILLEGAL`.
- Reset asserted mid-operation: all state clears on the next edge, a partial `acc` is discarded, and the FSM re-enters `INIT`.
- Pins at any level during reset produce no `err` when `INIT` exits.

## Structure
- Package `quad_pkg` contains:
  - `typedef enum logic {INIT, RUN} qd_state_t`.
  - `typedef enum logic [1:0] {NONE, INC, DEC, ILLEGAL} qd_step_t`.
  - Function `qd_decode(prev_ab, cur_ab)` returning `qd_step_t`.
  - Constant `QD_ACC_W = 3`.
- Sub-module `debounce_ch`, parameterized by `DEB_N`, instantiated once per channel:
  - Ports: `clk`, `rst`, `din`, `load`, `dout`.
  - `load` forces `dout <= din` during `INIT`.
- Top level holds the synchronizers, FSM, decode, accumulator and output registers.

## Test plan
- `DEB_N=4`, `DIV=1`, pins 00 through reset and `INIT`; drive AB 00→01 and hold → `en=1`, `cw=1` for exactly one cycle, following edge 6 after first sampling; `ab=01`.
- `DIV=4`: four clockwise steps 00→01→11→10→00, each held 10 cycles → a single `en` with `cw=1`, on the fourth step only.
- `DIV=4`: three clockwise steps, then three counter-clockwise → no `en`. Then four counter-clockwise steps → one `en` with `cw=0`.
- `DEB_N=4`: toggle `a_in` for 3 cycles, then restore → `ab` unchanged, `en=0`, `err=0`.
- In `RUN`, drive AB 00→11 simultaneously and hold → `err=1` for one cycle, `en=0`, `ab=11`, `acc` unchanged.
- Hold pins at 11 through reset → no `err` after `INIT`, `ab=11`. Set `acc=2` (`DIV=4`), pulse `rst` for 1 cycle → `acc=0`, `en=cw=err=0`, FSM back in `INIT`.
